pll_rate_arbiter: RTL and testbench

// - Owns the 2-bit rate select of the 10 MHz divider (PLL_10MHztoNHz) and shares it between two requesters (A, B).
// - Arbitrates round-robin, then applies the new select only just after a clk_pll toggle.
// - The divider samples the select only at its reload, so a commit here never truncates or stretches a half-period.
// - Sits between user/host control logic and the divider; all on clk_10MHz.

---
 rtl/pll_rate_arbiter.sv | 153 +++++++++++++++
 tb/tb_pll_rate_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rate_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pll_rate_arbiter : round-robin owner of the divider rate select; commits a new
// select only just after a clk_pll toggle. Option macro: RATE_ARB_TIMEOUT_EN
// Revision: 1.0
// -----------------------------------------------------------------------------
module pll_rate_arbiter #(
  parameter logic [1:0] RESET_SEL = 2'b00
`ifdef RATE_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
`endif
) (
  input  logic       clk_10MHz,
  input  logic       rstn,
  input  logic       clk_pll,
  input  logic       req_a,
  input  logic [1:0] sel_a,
  input  logic       req_b,
  input  logic [1:0] sel_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [1:0] clk_selector,
  output logic       busy,
  output logic       timeout_flag
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_ACK       = 2'd2;
  localparam logic       OWN_A        = 1'b0;
  localparam logic       OWN_B        = 1'b1;

  logic [1:0] state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       owner_q, owner_d;
  logic [1:0] pend_sel_q, pend_sel_d;
  logic [1:0] clk_selector_q, clk_selector_d;
  logic       clk_pll_q;

  logic       pll_edge;
  logic       req_owner;
  logic       force_commit;
  logic       elig_a, elig_b;
  logic       grant_valid;
  logic       grant_side;
  logic [1:0] grant_sel;

  assign pll_edge    = clk_pll ^ clk_pll_q;
  assign req_owner   = (owner_q == OWN_B) ? req_b : req_a;
  assign elig_a      = req_a & ~ack_a;
  assign elig_b      = req_b & ~ack_b;
  assign grant_valid = elig_a | elig_b;
  // With both eligible the pointer decides; otherwise the lone requester wins.
  assign grant_side  = (elig_a & elig_b) ? rr_ptr_q : (elig_b ? OWN_B : OWN_A);
  assign grant_sel   = (grant_side == OWN_B) ? sel_b : sel_a;

`ifdef RATE_ARB_TIMEOUT_EN
  localparam logic [24:0] TIMEOUT_LAST = 25'(TIMEOUT_CYCLES - 1);

  logic [24:0] to_cnt_q, to_cnt_d;
  logic        timeout_flag_q, timeout_flag_d;

  assign force_commit = (state_q == ST_WAIT_EDGE) && !pll_edge && (to_cnt_q == TIMEOUT_LAST);

  always_comb begin
    to_cnt_d       = '0;
    timeout_flag_d = timeout_flag_q;
    if ((state_q == ST_WAIT_EDGE) && (state_d == ST_WAIT_EDGE)) begin
      to_cnt_d = to_cnt_q + 25'd1;
    end
    if (force_commit && req_owner) begin
      timeout_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_10MHz or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q       <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      to_cnt_q       <= to_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  assign force_commit = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk_10MHz or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= OWN_A;
      owner_q        <= OWN_A;
      pend_sel_q     <= RESET_SEL;
      clk_selector_q <= RESET_SEL;
      clk_pll_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      pend_sel_q     <= pend_sel_d;
      clk_selector_q <= clk_selector_d;
      clk_pll_q      <= clk_pll;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    pend_sel_d     = pend_sel_q;
    clk_selector_d = clk_selector_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d    = grant_side;
          pend_sel_d = grant_sel;
          rr_ptr_d   = ~grant_side;
          state_d    = (grant_sel == clk_selector_q) ? ST_ACK : ST_WAIT_EDGE;
        end
      end
      ST_WAIT_EDGE: begin
        // A withdrawn request wins over a coincident edge: nothing is committed.
        if (!req_owner) begin
          state_d = ST_IDLE;
        end else if (pll_edge || force_commit) begin
          clk_selector_d = pend_sel_q;
          state_d        = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_owner) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    ack_a = (state_q == ST_ACK) && (owner_q == OWN_A);
    ack_b = (state_q == ST_ACK) && (owner_q == OWN_B);
  end

  assign clk_selector = clk_selector_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_rate_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pll_rate_arbiter : randomized transaction bench with a timing-rule model.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_pll_rate_arbiter;

  localparam int TO_CYC     = 32;
  localparam int WAIT_BOUND = 100;

  logic       clk_10MHz = 1'b0;
  logic       rstn      = 1'b0;
  logic       clk_pll   = 1'b0;
  logic       req_a     = 1'b0;
  logic [1:0] sel_a     = 2'b00;
  logic       req_b     = 1'b0;
  logic [1:0] sel_b     = 2'b00;
  logic       ack_a, ack_b, busy, timeout_flag;
  logic [1:0] clk_selector;

  always #5 clk_10MHz = ~clk_10MHz;

`ifdef RATE_ARB_TIMEOUT_EN
  pll_rate_arbiter #(.RESET_SEL(2'b00), .TIMEOUT_CYCLES(TO_CYC)) dut (
`else
  pll_rate_arbiter #(.RESET_SEL(2'b00)) dut (
`endif
    .clk_10MHz   (clk_10MHz),
    .rstn        (rstn),
    .clk_pll     (clk_pll),
    .req_a       (req_a),
    .sel_a       (sel_a),
    .req_b       (req_b),
    .sel_b       (sel_b),
    .ack_a       (ack_a),
    .ack_b       (ack_b),
    .clk_selector(clk_selector),
    .busy        (busy),
    .timeout_flag(timeout_flag)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // clk_pll source: toggles every 8 clocks while pll_run is set.
  int pll_phase    = 0;
  bit pll_run      = 1'b1;
  bit toggled_last = 1'b0;
  bit edge_now     = 1'b0;

  // Reference state: committed select, round-robin preference, sticky timeout.
  logic [1:0] m_sel = 2'b00;
  bit         m_rr  = 1'b0;
  bit         m_to  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_out(input string tag, input bit aa, input bit ab, input bit bz);
    check_eq({tag, ".sel"},   32'(clk_selector), 32'(m_sel));
    check_eq({tag, ".ack_a"}, 32'(ack_a),        32'(aa));
    check_eq({tag, ".ack_b"}, 32'(ack_b),        32'(ab));
    check_eq({tag, ".busy"},  32'(busy),         32'(bz));
    check_eq({tag, ".tflag"}, 32'(timeout_flag), 32'(m_to));
  endtask

  // One clock: sample slot is #1 after the edge; edge_now says whether a toggle
  // driven in the previous slot is visible to the DUT at this edge.
  task automatic tick();
    @(posedge clk_10MHz);
    #1;
    cyc++;
    edge_now     = toggled_last;
    toggled_last = 1'b0;
    pll_phase++;
    if (pll_phase >= 8) begin
      pll_phase = 0;
      if (pll_run) begin
        clk_pll      = ~clk_pll;
        toggled_last = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      expect_out("idle", 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Called right after the grant edge. Commit happens at the first later edge
  // with a clk_pll toggle (or after TO_CYC cycles when the timeout is built in).
  task automatic serve(input bit who, input logic [1:0] s, input int hold);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    if (s == m_sel) begin
      expect_out("match", !who, who, 1'b1);
    end else begin
      expect_out("grant", 1'b0, 1'b0, 1'b1);
      while (!done) begin
        tick();
        waited++;
        if (edge_now) begin
          m_sel = s;
          done  = 1'b1;
`ifdef RATE_ARB_TIMEOUT_EN
        end else if (waited == TO_CYC) begin
          m_sel = s;
          m_to  = 1'b1;
          done  = 1'b1;
`endif
        end else if (waited > WAIT_BOUND) begin
          check_eq("wait_bound", 32'(waited), 32'(WAIT_BOUND));
          return;
        end
        if (done) expect_out("commit", !who, who, 1'b1);
        else      expect_out("wait", 1'b0, 1'b0, 1'b1);
      end
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      expect_out("hold", !who, who, 1'b1);
    end
    if (who) req_b = 1'b0;
    else     req_a = 1'b0;
    tick();
    expect_out("release", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic txn(input bit ra, input bit rb, input logic [1:0] sa, input logic [1:0] sb);
    bit w;
    req_a = ra; sel_a = sa;
    req_b = rb; sel_b = sb;
    tick();
    w    = (ra && rb) ? m_rr : rb;
    m_rr = ~w;
    serve(w, w ? sb : sa, $urandom_range(0, 3));
    if (ra && rb) begin
      tick();
      m_rr = w;
      serve(~w, w ? sa : sb, $urandom_range(0, 3));
    end
  endtask

  // Requester A withdraws while waiting for an edge; the source is frozen so
  // no commit can occur first.
  task automatic abort_a(input int d);
    logic [1:0] s;
    s       = m_sel ^ 2'($urandom_range(1, 3));
    pll_run = 1'b0;
    req_a   = 1'b1; sel_a = s;
    req_b   = 1'b0;
    tick();
    m_rr = 1'b1;
    expect_out("abort.grant", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < d; i++) begin
      tick();
      expect_out("abort.wait", 1'b0, 1'b0, 1'b1);
    end
    req_a = 1'b0;
    tick();
    expect_out("abort.idle", 1'b0, 1'b0, 1'b0);
    pll_run = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    m_sel = 2'b00; m_rr = 1'b0; m_to = 1'b0;
    expect_out("reset", 1'b0, 1'b0, 1'b0);
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    expect_out("reset.hold", 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    idle(3);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    tick();
    expect_out("por", 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    idle(2);

    txn(1'b1, 1'b0, 2'b10, 2'b00);
    idle(2);
    txn(1'b1, 1'b1, 2'b01, 2'b11);
    idle(3);
    txn(1'b1, 1'b0, 2'b01, 2'b00);
    txn(1'b0, 1'b1, 2'b00, 2'b01);
    idle(1);
    abort_a(2);
    idle(2);

    // Reset while a grant waits for an edge.
    req_a = 1'b1; sel_a = m_sel ^ 2'b10;
    tick();
    tick();
    do_reset();
    txn(1'b1, 1'b1, 2'b11, 2'b10);

    for (int n = 0; n < 60; n++) begin
      idle($urandom_range(0, 9));
      kind = $urandom_range(0, 3);
      case (kind)
        0: txn(1'b1, 1'b0, 2'($urandom), 2'($urandom));
        1: txn(1'b0, 1'b1, 2'($urandom), 2'($urandom));
        2: txn(1'b1, 1'b1, 2'($urandom), 2'($urandom));
        default: abort_a($urandom_range(0, 5));
      endcase
    end

    // Frozen clk_pll with a select change outstanding.
    txn(1'b1, 1'b0, 2'b01, 2'b00);
    pll_run = 1'b0;
    req_a = 1'b1; sel_a = 2'b11; req_b = 1'b0;
    tick();
    m_rr = 1'b1;
`ifdef RATE_ARB_TIMEOUT_EN
    serve(1'b0, 2'b11, 2);
    pll_run = 1'b1;
    idle(2);
    txn(1'b0, 1'b1, 2'b00, 2'b10);
`else
    expect_out("stall.grant", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TO_CYC + 8; i++) begin
      tick();
      expect_out("stall.wait", 1'b0, 1'b0, 1'b1);
    end
    req_a = 1'b0;
    tick();
    expect_out("stall.abort", 1'b0, 1'b0, 1'b0);
    pll_run = 1'b1;
    idle(2);
`endif
    do_reset();
    txn(1'b1, 1'b1, 2'b10, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
